// File: rtl/rule_compactor_pkg.sv
// Shared constants and types for the rule-ID compactor: lane geometry,
// buffer depth, the compactor state encoding and the eop empty-byte rule.
package rule_compactor_pkg;

    localparam int RULE_AWIDTH   = 13;
    localparam int RULE_LANES    = 8;
    localparam int RULE_LANE_W   = 16;
    localparam int NO_RULE_EMPTY = 14;
    localparam int BUF_LANES     = 2 * RULE_LANES;
    localparam int CNT_W         = $clog2(BUF_LANES + 1);

    typedef logic [RULE_AWIDTH-1:0] rule_id_t;

    typedef enum logic {
        ST_PKT,
        ST_FLUSH
    } state_e;

    // Empty bytes of an eop beat holding n rules; n == 0 is the no-rule marker.
    function automatic logic [3:0] eop_empty(input logic [CNT_W-1:0] n);
        if (n == '0) begin
            return 4'(NO_RULE_EMPTY);
        end
        return 4'(2 * (RULE_LANES - int'(n)));
    endfunction

endpackage

// File: rtl/rule_compactor_lane_compress.sv
// Packs the nonzero lanes of one beat into a dense vector (input order kept)
// and reports how many survived.
module lane_compress
    import rule_compactor_pkg::*;
(
    input  logic [RULE_LANES-1:0][RULE_AWIDTH-1:0] i_lanes,
    output logic [RULE_LANES-1:0][RULE_AWIDTH-1:0] o_dense,
    output logic [3:0]                             o_count
);

    logic [RULE_LANES-1:0] w_valid;
    logic [2:0]            w_rank [RULE_LANES];

    genvar gi;
    generate
        for (gi = 0; gi < RULE_LANES; gi++) begin : g_valid
            assign w_valid[gi] = |i_lanes[gi];
        end
    endgenerate

    // Exclusive prefix popcount: rank of each valid lane among valid lanes.
    always_comb begin
        logic [3:0] v_run;
        v_run = '0;
        for (int i = 0; i < RULE_LANES; i++) begin
            w_rank[i] = v_run[2:0];
            v_run     = v_run + 4'(w_valid[i]);
        end
        o_count = v_run;
    end

    always_comb begin
        o_dense = '0;
        for (int k = 0; k < RULE_LANES; k++) begin
            for (int i = 0; i < RULE_LANES; i++) begin
                if (w_valid[i] && (w_rank[i] == 3'(k))) begin
                    o_dense[k] = i_lanes[i];
                end
            end
        end
    end

endmodule

// File: rtl/rule_compactor.sv
// Drops zero rule-ID lanes from a sparse beat stream and repacks the survivors
// into dense 8-lane beats per packet; a rule-less packet becomes one marker beat.
module rule_compactor
    import rule_compactor_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RULE_LANES*RULE_LANE_W-1:0]   in_usr_data,
    input  logic                                in_usr_valid,
    input  logic                                in_usr_sop,
    input  logic                                in_usr_eop,
    input  logic [3:0]                          in_usr_empty,
    output logic                                in_usr_ready,
    output logic [RULE_LANES*RULE_LANE_W-1:0]   out_usr_data,
    output logic                                out_usr_valid,
    output logic                                out_usr_sop,
    output logic                                out_usr_eop,
    output logic [3:0]                          out_usr_empty,
    input  logic                                out_usr_ready,
    output logic [31:0]                         in_rule_cnt,
    output logic [31:0]                         out_pkt_cnt
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'(RULE_LANES);

    state_e           r_state, w_state_next;
    rule_id_t         r_buf      [BUF_LANES];
    rule_id_t         w_shift    [BUF_LANES];
    rule_id_t         w_buf_next [BUF_LANES];
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_base;
    logic             r_sop;
    logic             w_accept, w_emit;
    logic [3:0]       w_dense_cnt;
    logic             w_unused_ok;

    logic [RULE_LANES-1:0][RULE_AWIDTH-1:0]             w_lanes, w_dense;
    logic [RULE_LANES-1:0][RULE_LANE_W-RULE_AWIDTH-1:0] w_lane_hi;

    genvar gi;
    generate
        for (gi = 0; gi < RULE_LANES; gi++) begin : g_lane
            assign w_lanes[gi]   = in_usr_data[gi*RULE_LANE_W +: RULE_AWIDTH];
            assign w_lane_hi[gi] = in_usr_data[gi*RULE_LANE_W+RULE_AWIDTH +: RULE_LANE_W-RULE_AWIDTH];
            assign out_usr_data[gi*RULE_LANE_W +: RULE_LANE_W] =
                {{(RULE_LANE_W-RULE_AWIDTH){1'b0}}, r_buf[gi]};
            assign w_shift[gi]            = w_emit ? r_buf[gi+RULE_LANES] : r_buf[gi];
            assign w_shift[gi+RULE_LANES] = w_emit ? '0 : r_buf[gi+RULE_LANES];
        end
    endgenerate

    // Upper lane bits, input sop and input empty carry no information here.
    assign w_unused_ok = &{1'b0, w_lane_hi, in_usr_sop, in_usr_empty};

    lane_compress u_compress (
        .i_lanes (w_lanes),
        .o_dense (w_dense),
        .o_count (w_dense_cnt)
    );

    always_comb begin
        w_state_next  = r_state;
        in_usr_ready  = 1'b0;
        out_usr_valid = 1'b0;
        out_usr_eop   = 1'b0;
        out_usr_empty = '0;
        case (r_state)
            ST_PKT: begin
                // Emit only above one beat's worth so the eop beat is never empty.
                in_usr_ready  = !rst && ((r_cnt <= HALF) || out_usr_ready);
                out_usr_valid = (r_cnt > HALF);
                if (in_usr_valid && in_usr_ready && in_usr_eop) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                out_usr_valid = 1'b1;
                if (r_cnt <= HALF) begin
                    out_usr_eop   = 1'b1;
                    out_usr_empty = eop_empty(r_cnt);
                    if (out_usr_ready) begin
                        w_state_next = ST_PKT;
                    end
                end
            end
            default: w_state_next = ST_PKT;
        endcase
    end

    assign out_usr_sop = r_sop;
    assign w_accept    = in_usr_valid && in_usr_ready;
    assign w_emit      = out_usr_valid && out_usr_ready;
    assign w_base      = w_emit ? (r_cnt - HALF) : r_cnt;

    // Entries at or above cnt are kept zero, so unused output lanes read zero.
    always_comb begin
        logic [CNT_W-1:0] v_idx;
        v_idx      = '0;
        w_buf_next = w_shift;
        w_cnt_next = w_accept ? (w_base + CNT_W'(w_dense_cnt)) : w_base;
        for (int j = 0; j < BUF_LANES; j++) begin
            v_idx = CNT_W'(j) - w_base;
            if (w_accept && (CNT_W'(j) >= w_base) && (v_idx < CNT_W'(w_dense_cnt))) begin
                w_buf_next[j] = w_dense[v_idx[2:0]];
            end
        end
        if (w_emit && out_usr_eop) begin
            w_cnt_next = '0;
            for (int j = 0; j < BUF_LANES; j++) begin
                w_buf_next[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_PKT;
            r_cnt       <= '0;
            r_sop       <= 1'b1;
            in_rule_cnt <= '0;
            out_pkt_cnt <= '0;
            for (int i = 0; i < BUF_LANES; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            for (int i = 0; i < BUF_LANES; i++) begin
                r_buf[i] <= w_buf_next[i];
            end
            if (w_emit) begin
                r_sop <= out_usr_eop;
            end
            if (w_accept) begin
                in_rule_cnt <= in_rule_cnt + 32'(w_dense_cnt);
            end
            if (w_emit && out_usr_eop) begin
                out_pkt_cnt <= out_pkt_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rule_compactor.sv
// Bench for rule_compactor: directed packets then random traffic, with output
// beats compared against packets rebuilt from the accepted rule-ID lists.
module tb_rule_compactor;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_usr_data;
    logic         in_usr_valid, in_usr_sop, in_usr_eop;
    logic [3:0]   in_usr_empty;
    logic         in_usr_ready;
    logic [127:0] out_usr_data;
    logic         out_usr_valid, out_usr_sop, out_usr_eop;
    logic [3:0]   out_usr_empty;
    logic         out_usr_ready;
    logic [31:0]  in_rule_cnt, out_pkt_cnt;

    always #5 clk = ~clk;

    rule_compactor dut (
        .clk           (clk),
        .rst           (rst),
        .in_usr_data   (in_usr_data),
        .in_usr_valid  (in_usr_valid),
        .in_usr_sop    (in_usr_sop),
        .in_usr_eop    (in_usr_eop),
        .in_usr_empty  (in_usr_empty),
        .in_usr_ready  (in_usr_ready),
        .out_usr_data  (out_usr_data),
        .out_usr_valid (out_usr_valid),
        .out_usr_sop   (out_usr_sop),
        .out_usr_eop   (out_usr_eop),
        .out_usr_empty (out_usr_empty),
        .out_usr_ready (out_usr_ready),
        .in_rule_cnt   (in_rule_cnt),
        .out_pkt_cnt   (out_pkt_cnt)
    );

    typedef struct packed {
        logic [127:0] data;
        logic         eop;
    } in_beat_t;

    typedef struct packed {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   empty;
    } out_beat_t;

    in_beat_t    in_q[$];
    out_beat_t   exp_q[$];
    out_beat_t   obs_q[$];
    logic [12:0] cur_ids[$];

    int          checks = 0;
    int          errors = 0;
    int unsigned m_rule_cnt = 0;
    int unsigned m_pkt_cnt  = 0;
    int          held = 0;
    bit          flushing = 1'b0;
    bit          cnt_due = 1'b0;
    bit          prev_stalled = 1'b0;
    out_beat_t   prev_beat;
    int          rdy_pct = 100;
    int          vld_pct = 100;
    int          stall_left = 0;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected output of a finished packet: its rule list cut into chunks of 8.
    task automatic close_packet();
        int        n;
        int        left;
        out_beat_t e;
        n = cur_ids.size();
        if (n == 0) begin
            e = '{data: '0, sop: 1'b1, eop: 1'b1, empty: 4'd14};
            exp_q.push_back(e);
        end else begin
            for (int b = 0; b * 8 < n; b++) begin
                e.data = '0;
                for (int k = 0; k < 8; k++) begin
                    if (b * 8 + k < n) e.data[16*k +: 16] = {3'b000, cur_ids[b*8+k]};
                end
                left    = n - b * 8;
                e.sop   = (b == 0);
                e.eop   = (left <= 8);
                e.empty = e.eop ? 4'(2 * (8 - left)) : 4'd0;
                exp_q.push_back(e);
            end
        end
        cur_ids.delete();
    endtask

    task automatic model_accept(input in_beat_t bt);
        for (int k = 0; k < 8; k++) begin
            if (bt.data[16*k +: 13] != 13'd0) begin
                cur_ids.push_back(bt.data[16*k +: 13]);
                m_rule_cnt++;
                held++;
            end
        end
        if (bt.eop) begin
            close_packet();
            flushing = 1'b1;
        end
    endtask

    task automatic step();
        bit        acc;
        bit        emi;
        out_beat_t obs;
        out_beat_t e;
        out_beat_t o;
        @(negedge clk);
        if (stall_left > 0) begin
            out_usr_ready = 1'b0;
            stall_left--;
        end else begin
            out_usr_ready = ($urandom_range(99) < rdy_pct);
        end
        if (in_q.size() > 0 && $urandom_range(99) < vld_pct) begin
            in_usr_valid = 1'b1;
            in_usr_data  = in_q[0].data;
            in_usr_eop   = in_q[0].eop;
        end else begin
            in_usr_valid = 1'b0;
            in_usr_data  = {$urandom, $urandom, $urandom, $urandom};
            in_usr_eop   = 1'($urandom);
        end
        in_usr_sop   = 1'($urandom);
        in_usr_empty = 4'($urandom);
        #1;
        if (cnt_due) begin
            check("in_rule_cnt", in_rule_cnt, m_rule_cnt);
            check("out_pkt_cnt", out_pkt_cnt, m_pkt_cnt);
        end
        check("in_ready", in_usr_ready, !flushing && (held <= 8 || out_usr_ready));
        check("out_valid", out_usr_valid, flushing || held > 8);
        obs = '{data: out_usr_data, sop: out_usr_sop, eop: out_usr_eop, empty: out_usr_empty};
        if (prev_stalled) check("stall_hold", obs, prev_beat);
        acc = in_usr_valid && in_usr_ready;
        emi = out_usr_valid && out_usr_ready;
        prev_stalled = out_usr_valid && !out_usr_ready;
        prev_beat    = obs;
        if (emi) begin
            obs_q.push_back(obs);
            if (out_usr_eop) begin
                held     = 0;
                flushing = 1'b0;
                m_pkt_cnt++;
            end else begin
                held -= 8;
            end
        end
        if (acc) model_accept(in_q.pop_front());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check("beat_data", o.data, e.data);
            check("beat_sop", o.sop, e.sop);
            check("beat_eop", o.eop, e.eop);
            check("beat_empty", o.empty, e.empty);
        end
        cnt_due = acc || emi;
    endtask

    function automatic bit is_idle();
        return in_q.size() == 0 && exp_q.size() == 0 && obs_q.size() == 0 && !flushing && held == 0;
    endfunction

    task automatic run_until_idle(input string tag, input int budget, input bit bursts);
        int n;
        n = 0;
        while (!is_idle() && n < budget) begin
            if (bursts && $urandom_range(63) == 0) stall_left = $urandom_range(2, 12);
            step();
            n++;
        end
        check({tag, "_idle"}, is_idle(), 1'b1);
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        in_usr_valid  = 1'b0;
        out_usr_ready = 1'b0;
        #1;
        check("rst_in_ready", in_usr_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_usr_valid, 1'b0);
        check("rst_out_sop", out_usr_sop, 1'b1);
        check("rst_rule_cnt", in_rule_cnt, 32'd0);
        check("rst_pkt_cnt", out_pkt_cnt, 32'd0);
        check("rst_in_ready_after", in_usr_ready, 1'b1);
        in_q.delete();
        exp_q.delete();
        obs_q.delete();
        cur_ids.delete();
        m_rule_cnt   = 0;
        m_pkt_cnt    = 0;
        held         = 0;
        flushing     = 1'b0;
        cnt_due      = 1'b0;
        prev_stalled = 1'b0;
    endtask

    task automatic push_beat(input logic [127:0] d, input bit eop);
        in_beat_t bt;
        bt = '{data: d, eop: eop};
        in_q.push_back(bt);
    endtask

    task automatic push_seq(input int first, input int count);
        logic [127:0] d;
        for (int b = 0; b * 8 < count; b++) begin
            d = '0;
            for (int k = 0; k < 8; k++) begin
                if (b * 8 + k < count) d[16*k +: 16] = 16'(first + b * 8 + k);
            end
            push_beat(d, (b + 1) * 8 >= count);
        end
    endtask

    task automatic push_random_packets(input int npkt);
        int           nb;
        int           dens;
        logic [127:0] d;
        logic [15:0]  lane;
        for (int p = 0; p < npkt; p++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                dens = $urandom_range(0, 4);
                for (int k = 0; k < 8; k++) begin
                    lane = 16'($urandom);
                    if ($urandom_range(3) >= dens) lane[12:0] = 13'd0;
                    d[16*k +: 16] = lane;
                end
                push_beat(d, b == nb - 1);
            end
        end
    endtask

    initial begin
        logic [127:0] d;
        int           n;
        rst           = 1'b1;
        in_usr_valid  = 1'b0;
        in_usr_data   = '0;
        in_usr_sop    = 1'b0;
        in_usr_eop    = 1'b0;
        in_usr_empty  = '0;
        out_usr_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        // Sparse single-beat packet {0,5,0,7,...}.
        d = '0;
        d[16*1 +: 16] = 16'd5;
        d[16*3 +: 16] = 16'd7;
        push_beat(d, 1'b1);
        run_until_idle("t1", 50, 1'b0);

        // Packet with no surviving rules.
        push_beat('0, 1'b1);
        run_until_idle("t2", 50, 1'b0);

        // Three dense beats, then the same with a 10-cycle downstream stall.
        push_seq(1, 24);
        run_until_idle("t3", 50, 1'b0);
        push_seq(1, 24);
        stall_left = 10;
        run_until_idle("t4", 80, 1'b0);

        // Back-to-back packets, and an all-zero non-eop beat mid-packet.
        d = '0;
        d[15:0] = 16'd3;
        push_beat(d, 1'b1);
        d = '0;
        d[15:0]  = 16'd4;
        d[47:32] = 16'd9;
        push_beat(d, 1'b1);
        push_beat('0, 1'b0);
        d = '0;
        d[31:16] = 16'hE002;
        push_beat(d, 1'b1);
        run_until_idle("t5", 80, 1'b0);

        // 8 + 4 rules held in FLUSH with downstream blocked, then reset.
        stall_left = 1000;
        push_seq(31, 8);
        push_seq(41, 4);
        in_q[0].eop = 1'b0;
        n = 0;
        while (in_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        check("t6_flushing", flushing, 1'b1);
        do_reset();
        stall_left = 0;
        d = '0;
        d[15:0] = 16'd6;
        push_beat(d, 1'b1);
        run_until_idle("t6", 50, 1'b0);

        // Random traffic with random ready, valid gaps and stall bursts.
        rdy_pct = 70;
        vld_pct = 75;
        push_random_packets(60);
        run_until_idle("rand", 20000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
